// File: rtl/mc_datapath_pkg.sv
// Shared definitions for the multicycle ARM-subset datapath: control field
// encodings, ALU flag bit positions, register-file geometry and the
// immediate extender.
package mc_datapath_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALUOUT     = 2'b00,
    RES_DATA       = 2'b01,
    RES_ALURESULT  = 2'b10,
    RES_ALUOUT_ALT = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    SRCB_REG      = 2'b00,
    SRCB_IMM      = 2'b01,
    SRCB_FOUR     = 2'b10,
    SRCB_FOUR_ALT = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    IMM_ZEXT8      = 2'b00,
    IMM_ZEXT12     = 2'b01,
    IMM_BRANCH     = 2'b10,
    IMM_BRANCH_ALT = 2'b11
  } imm_src_e;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // R0..R14 are stored; address 15 is the PC alias and has no storage.
  localparam int         NUM_REGS = 15;
  localparam logic [3:0] REG_PC   = 4'd15;

  // Immediate extender: data-processing immediates are zero-extended,
  // branch offsets are sign-extended word offsets.
  function automatic logic [31:0] extend_imm(input logic [23:0] imm,
                                             input logic [1:0]  src);
    case (src)
      IMM_ZEXT8:  extend_imm = {24'b0, imm[7:0]};
      IMM_ZEXT12: extend_imm = {20'b0, imm[11:0]};
      default:    extend_imm = {{6{imm[23]}}, imm, 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/mc_datapath_regfile.sv
// mc_regfile: 15 x 32 register file for R0..R14.
//   clk_i, reset_i     : clock, asynchronous active-high reset
//   we_i, wa_i, wd_i   : synchronous write port (writes to address 15 dropped)
//   ra1_i/rd1_o        : combinational read port 1
//   ra2_i/rd2_o        : combinational read port 2
//   r15_i              : value returned for reads of address 15
// A read of the register being written in the same cycle sees the old value.
module mc_regfile
  import mc_datapath_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        we_i,
  input  logic [3:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [3:0]  ra1_i,
  input  logic [3:0]  ra2_i,
  input  logic [31:0] r15_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs_q [NUM_REGS];

  // NOTE: the array is cleared on reset because the architecture promises
  // R0..R14 = 0; without that requirement leaving storage unreset is cheaper.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != REG_PC)) begin
      // NOTE: non-blocking so every reader this cycle still sees the old value.
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == REG_PC) ? r15_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == REG_PC) ? r15_i : regs_q[ra2_i];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle ARM-subset datapath (PC, IR, Data, register file,
// A/B operand registers, ALU, ALUOut) between the controller and a single
// shared instruction/data memory.
//   clk, reset            : clock, asynchronous active-high reset
//   PCWrite/IRWrite       : load enables for PC (from Result) and IR (from ReadData)
//   RegWrite              : write Result into register Instr[15:12]
//   MemWrite              : forwarded unchanged to MemWE
//   AdrSrc, RegSrc        : memory address and register read-address selects
//   ALUSrcA, ALUSrcB      : ALU operand selects
//   ResultSrc, ImmSrc     : Result mux select, immediate format
//   ALUControl            : ADD/SUB/AND/ORR
//   ReadData              : memory read data (combinational w.r.t. Adr)
//   Adr, WriteData, MemWE : memory interface
//   Instr, ALUFlags       : IR contents and live {N,Z,C,V} to the controller
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        IRWrite,
  input  logic        AdrSrc,
  input  logic [1:0]  RegSrc,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  ResultSrc,
  input  logic [1:0]  ImmSrc,
  input  logic [1:0]  ALUControl,
  input  logic [31:0] ReadData,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  output logic        MemWE,
  output logic [31:0] Instr,
  output logic [3:0]  ALUFlags
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] data_q, a_q, b_q, aluout_q;

  logic [3:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic [31:0] ext_imm, src_a, src_b, alu_result, result;

  // ---------------------------------------------------------------- state
  assign pc_d = PCWrite ? result   : pc_q;
  assign ir_d = IRWrite ? ReadData : ir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      data_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      data_q   <= ReadData;
      a_q      <= rd1;
      b_q      <= rd2;
      aluout_q <= alu_result;
    end
  end

  // ---------------------------------------------------------- register file
  assign ra1 = RegSrc[0] ? REG_PC     : ir_q[19:16];
  assign ra2 = RegSrc[1] ? ir_q[15:12] : ir_q[3:0];

  // R15 reads return the live Result, which in a fetch/decode sequence is PC+4
  // (or PC+8 one cycle later) without a separate PC+8 adder.
  mc_regfile u_regfile (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (RegWrite),
    .wa_i    (ir_q[15:12]),
    .wd_i    (result),
    .ra1_i   (ra1),
    .ra2_i   (ra2),
    .r15_i   (result),
    .rd1_o   (rd1),
    .rd2_o   (rd2)
  );

  // ------------------------------------------------------------ operands
  assign ext_imm = extend_imm(ir_q[23:0], ImmSrc);
  assign src_a   = ALUSrcA ? pc_q : a_q;

  always_comb begin
    // NOTE: default first so no path through the case can infer a latch.
    src_b = 32'd4;
    case (ALUSrcB)
      SRCB_REG: src_b = b_q;
      SRCB_IMM: src_b = ext_imm;
      default:  src_b = 32'd4;
    endcase
  end

  // ------------------------------------------------------------------ ALU
  logic [31:0] b_op;
  logic [32:0] sum;
  logic        carry, overflow;

  always_comb begin
    // Subtraction is a + ~b + 1, so one adder serves both ADD and SUB. With
    // the inverted operand, the ADD overflow rule also yields the SUB rule.
    b_op       = (ALUControl == ALU_SUB) ? ~src_b : src_b;
    sum        = {1'b0, src_a} + {1'b0, b_op} + {32'b0, (ALUControl == ALU_SUB)};
    alu_result = sum[31:0];
    carry      = 1'b0;
    overflow   = 1'b0;
    case (ALUControl)
      ALU_ADD, ALU_SUB: begin
        alu_result = sum[31:0];
        carry      = sum[32];
        overflow   = (src_a[31] == b_op[31]) && (sum[31] != src_a[31]);
      end
      ALU_AND: alu_result = src_a & src_b;
      default: alu_result = src_a | src_b;
    endcase
  end

  always_comb begin
    ALUFlags         = '0;
    ALUFlags[FLAG_N] = alu_result[31];
    ALUFlags[FLAG_Z] = (alu_result == 32'd0);
    ALUFlags[FLAG_C] = carry;
    ALUFlags[FLAG_V] = overflow;
  end

  // --------------------------------------------------------- result / memory
  always_comb begin
    result = aluout_q;
    case (ResultSrc)
      RES_DATA:      result = data_q;
      RES_ALURESULT: result = alu_result;
      default:       result = aluout_q;
    endcase
  end

  assign Adr       = AdrSrc ? result : pc_q;
  assign WriteData = b_q;
  assign MemWE     = MemWrite;
  assign Instr     = ir_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed testbench for mc_datapath. The stimulus process applies controls
// each cycle and queues the hand-computed expected outputs for that cycle;
// an independent monitor samples the DUT on the falling edge and retires
// queued expectations against what it sees.
module tb_mc_datapath;
  import mc_datapath_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [31:0] ReadData;
  logic [31:0] Adr, WriteData, Instr;
  logic        MemWE;
  logic [3:0]  ALUFlags;

  mc_datapath #(.PC_RESET(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .ReadData   (ReadData),
    .Adr        (Adr),
    .WriteData  (WriteData),
    .MemWE      (MemWE),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef enum int {OBS_ADR, OBS_INSTR, OBS_WDATA, OBS_FLAGS, OBS_MEMWE} obs_e;
  typedef struct {
    int          cyc;
    obs_e        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] observe(input obs_e sel);
    case (sel)
      OBS_ADR:   observe = Adr;
      OBS_INSTR: observe = Instr;
      OBS_WDATA: observe = WriteData;
      OBS_FLAGS: observe = {28'b0, ALUFlags};
      default:   observe = {31'b0, MemWE};
    endcase
  endfunction

  // Monitor: retire every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      if (mon_e.cyc != cyc_cnt) begin
        n_err++;
        $display("FAIL %s: sampled in cycle %0d, required cycle %0d",
                 mon_e.name, cyc_cnt, mon_e.cyc);
      end else if (observe(mon_e.sel) !== mon_e.exp) begin
        n_err++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h",
                 mon_e.name, observe(mon_e.sel), mon_e.exp);
      end
    end
  end

  task automatic expect_val(input obs_e sel, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.sel  = sel;
    e.exp  = v;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    PCWrite = 0; MemWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0;
    ALUSrcA = 0; RegSrc = 2'b00; ALUSrcB = SRCB_REG; ResultSrc = RES_ALUOUT;
    ImmSrc = IMM_ZEXT8; ALUControl = ALU_ADD; ReadData = '0;
  endtask

  // Advance to just after the next rising edge with all controls idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic fetch(input logic [31:0] word);
    AdrSrc = 0; IRWrite = 1; ALUSrcA = 1; ALUSrcB = SRCB_FOUR;
    ResultSrc = RES_ALURESULT; PCWrite = 1; ReadData = word;
  endtask

  // ALU op on A/B with the result routed to Adr; RegSrc=11 feeds Result back into A.
  task automatic alu_rr(input logic [1:0] op);
    ALUControl = op; ALUSrcB = SRCB_REG; ResultSrc = RES_ALURESULT;
    AdrSrc = 1; RegSrc = 2'b11;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // ---- reset state
    next_cycle();
    expect_val(OBS_ADR,   32'h0, "rst_adr");
    expect_val(OBS_INSTR, 32'h0, "rst_instr");
    expect_val(OBS_WDATA, 32'h0, "rst_wdata");
    expect_val(OBS_MEMWE, 32'h0, "rst_memwe");
    next_cycle();
    AdrSrc = 1;
    expect_val(OBS_ADR, 32'h0, "rst_aluout");

    // ---- load PC=0x40, then reset mid-operation
    next_cycle();
    reset = 1'b0;
    fetch(32'hE3A0_0040);
    expect_val(OBS_ADR,   32'h0, "fetch0_adr");
    expect_val(OBS_FLAGS, 32'h0, "fetch0_flags");
    next_cycle();                               // A=R0=0, Result=0+0x40
    ALUSrcB = SRCB_IMM; ImmSrc = IMM_ZEXT8; ResultSrc = RES_ALURESULT; PCWrite = 1;
    expect_val(OBS_INSTR, 32'hE3A0_0040, "ir_loaded");
    expect_val(OBS_ADR,   32'h4,         "pc_after_fetch0");
    next_cycle();
    ALUSrcA = 1; ALUSrcB = SRCB_FOUR;           // ALUOut <= 0x44
    expect_val(OBS_ADR, 32'h40, "pc_loaded_0x40");
    next_cycle();
    reset = 1'b1;                               // asynchronous: clears before next edge
    expect_val(OBS_ADR,   32'h0, "rst_mid_pc");
    expect_val(OBS_INSTR, 32'h0, "rst_mid_ir");
    next_cycle();
    AdrSrc = 1;
    expect_val(OBS_ADR, 32'h0, "rst_mid_aluout");

    // ---- fetch from PC_RESET, Data register
    next_cycle();
    reset = 1'b0;
    fetch(32'hE281_1005);                       // ADD R1,R1,#5
    expect_val(OBS_ADR, 32'h0, "fetch_after_rst");
    next_cycle();
    AdrSrc = 1; ResultSrc = RES_DATA;
    expect_val(OBS_INSTR, 32'hE281_1005, "fetch_instr");
    expect_val(OBS_ADR,   32'hE281_1005, "data_reg");
    next_cycle();
    ReadData = 32'd7;
    expect_val(OBS_ADR, 32'h4, "pc_plus4");

    // ---- R1=7, read-during-write, ADD immediate
    next_cycle();
    ResultSrc = RES_DATA; RegWrite = 1;         // R1 <= 7; A still samples old R1=0
    next_cycle();
    ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURESULT; AdrSrc = 1;
    expect_val(OBS_ADR, 32'd5, "rf_read_old_value");
    next_cycle();
    ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURESULT; AdrSrc = 1;
    expect_val(OBS_ADR,   32'd12, "add_imm_result");
    expect_val(OBS_FLAGS, 32'h0,  "add_imm_flags");
    next_cycle();
    ResultSrc = RES_ALUOUT; AdrSrc = 1; RegWrite = 1;  // R1 <= ALUOut
    expect_val(OBS_ADR, 32'd12, "aluout_reg");
    next_cycle();
    next_cycle();
    ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURESULT; AdrSrc = 1;
    expect_val(OBS_ADR, 32'd17, "r1_writeback");

    // ---- SUB cases (instr Rn=1, Rd=2, Rm=3)
    next_cycle();
    fetch(32'hE051_2003);
    expect_val(OBS_ADR, 32'h4, "fetch2_adr");
    next_cycle();
    ReadData = 32'h10;
    next_cycle();
    ResultSrc = RES_DATA; RegWrite = 1; ReadData = 32'h10;   // R2 <= 0x10
    next_cycle();
    RegSrc = 2'b11; ResultSrc = RES_DATA;                    // A <= Result, B <= R2
    next_cycle();
    alu_rr(ALU_SUB); RegSrc = 2'b00; MemWrite = 1;
    expect_val(OBS_FLAGS, 32'b0110, "sub_eq_flags");
    expect_val(OBS_ADR,   32'h0,    "sub_eq_result");
    expect_val(OBS_WDATA, 32'h10,   "wdata_is_b");
    expect_val(OBS_MEMWE, 32'h1,    "memwe_high");
    next_cycle();
    ReadData = 32'hFFFF_FFFF;
    expect_val(OBS_MEMWE, 32'h0, "memwe_low");
    next_cycle();
    ResultSrc = RES_DATA; RegWrite = 1; ReadData = 32'h7FFF_FFFF;  // R2 <= FFFFFFFF
    next_cycle();
    RegSrc = 2'b11; ResultSrc = RES_DATA;       // A <= 7FFFFFFF, B <= FFFFFFFF
    next_cycle();
    alu_rr(ALU_SUB);
    expect_val(OBS_ADR,   32'h8000_0000, "sub_ovf_result");
    expect_val(OBS_FLAGS, 32'b1001,      "sub_ovf_flags");
    expect_val(OBS_WDATA, 32'hFFFF_FFFF, "sub_ovf_b");
    next_cycle();
    alu_rr(ALU_AND);                            // 80000000 & FFFFFFFF
    expect_val(OBS_ADR,   32'h8000_0000, "and_result");
    expect_val(OBS_FLAGS, 32'b1000,      "and_flags");
    next_cycle();
    alu_rr(ALU_ADD);                            // 80000000 + FFFFFFFF
    expect_val(OBS_ADR,   32'h7FFF_FFFF, "add_cv_result");
    expect_val(OBS_FLAGS, 32'b0011,      "add_cv_flags");
    next_cycle();
    alu_rr(ALU_ORR);                            // 7FFFFFFF | FFFFFFFF
    expect_val(OBS_ADR,   32'hFFFF_FFFF, "orr_result");
    expect_val(OBS_FLAGS, 32'b1000,      "orr_flags");

    // ---- branch extend, R15 read/write (instr Rn=Rd=15)
    next_cycle();
    fetch(32'hEAFF_FFFE);
    expect_val(OBS_ADR, 32'h8, "fetch3_adr");
    next_cycle();
    ALUSrcA = 1; ALUSrcB = SRCB_IMM; ImmSrc = IMM_BRANCH;
    ResultSrc = RES_ALURESULT; AdrSrc = 1;      // 0xC + 0xFFFFFFF8
    expect_val(OBS_ADR,   32'h4,    "br_ext_result");
    expect_val(OBS_FLAGS, 32'b0010, "br_ext_flags");
    next_cycle();
    ALUSrcA = 1; ALUSrcB = SRCB_IMM; ImmSrc = IMM_ZEXT12;
    ResultSrc = RES_ALURESULT; AdrSrc = 1;      // 0xC + 0xFFE
    expect_val(OBS_ADR, 32'h100A, "imm12_zext");
    next_cycle();
    ALUSrcA = 1; ALUSrcB = SRCB_IMM; ImmSrc = IMM_ZEXT8;
    ResultSrc = RES_ALURESULT; AdrSrc = 1;      // 0xC + 0xFE
    expect_val(OBS_ADR, 32'h10A, "imm8_zext");
    next_cycle();
    ALUSrcA = 1; ALUSrcB = SRCB_IMM; ImmSrc = IMM_BRANCH_ALT;
    ResultSrc = RES_ALURESULT; AdrSrc = 1;
    expect_val(OBS_ADR, 32'h4, "imm_src_11");
    next_cycle();
    RegSrc = 2'b01; ALUSrcA = 1; ALUSrcB = SRCB_FOUR;
    ResultSrc = RES_ALURESULT; RegWrite = 1;    // A <= R15 = 0x10; write to R15 dropped
    next_cycle();
    ALUSrcB = SRCB_FOUR_ALT;                    // ALUOut <= A + 4 = 0x14
    expect_val(OBS_ADR, 32'hC, "r15_write_dropped");
    next_cycle();
    AdrSrc = 1; ResultSrc = RES_ALUOUT_ALT;
    expect_val(OBS_ADR, 32'h14, "r15_read_result");

    // ---- load/store path
    next_cycle();
    ReadData = 32'h100;
    next_cycle();
    RegSrc = 2'b11; ResultSrc = RES_DATA;       // A, B <= 0x100
    next_cycle();
    alu_rr(ALU_ORR); AdrSrc = 0;                // ALUOut <= 0x100
    next_cycle();
    AdrSrc = 1; ResultSrc = RES_ALUOUT; ReadData = 32'hDEAD_BEEF; MemWrite = 1;
    expect_val(OBS_ADR,   32'h100, "ldst_adr");
    expect_val(OBS_MEMWE, 32'h1,   "st_memwe");
    expect_val(OBS_WDATA, 32'h100, "st_wdata");
    next_cycle();
    AdrSrc = 1; ResultSrc = RES_DATA;
    expect_val(OBS_ADR, 32'hDEAD_BEEF, "ld_data");

    // ---- PC wrap-around
    next_cycle();
    ReadData = 32'hFFFF_FFFC;
    next_cycle();
    ResultSrc = RES_DATA; PCWrite = 1;
    next_cycle();
    fetch(32'hE1A0_0000);
    expect_val(OBS_ADR,   32'hFFFF_FFFC, "pc_top");
    expect_val(OBS_FLAGS, 32'b0110,      "pc_wrap_flags");
    next_cycle();
    expect_val(OBS_ADR,   32'h0,         "pc_wrap");
    expect_val(OBS_INSTR, 32'hE1A0_0000, "fetch_at_top");

    // ---- drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) next_cycle();
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: never sampled, expected 0x%08h", mon_e.name, mon_e.exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: run did not complete, %0d expectations pending", sb_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
